// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 timing constants, axis phase encoding and coordinate type.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package vga_timing_pkg;

    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;
    localparam int VGA_H_TOTAL  = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;

    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;
    localparam int VGA_V_TOTAL  = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

    // Phase of one axis (horizontal pixels or vertical lines).
    typedef enum logic [1:0] {
        PH_ACTIVE = 2'd0,
        PH_FP     = 2'd1,
        PH_SYNC   = 2'd2,
        PH_BP     = 2'd3
    } phase_e;

    // Pixel column / line index.
    typedef logic [9:0] coord_t;

endpackage

// File: rtl/vga_axis_counter.sv
// One VGA axis: wrapping position counter plus ACTIVE/FP/SYNC/BP phase tracker.
// Latency: count registered; phase/wrap are combinational views of the position being entered / current wrap point.
// Backpressure: none; state moves only on i_adv and holds otherwise.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int ACTIVE = 640,
    parameter int FP     = 16,
    parameter int SYNC   = 96,
    parameter int BP     = 48
) (
    input  logic   i_clk,
    input  logic   i_rst,
    input  logic   i_adv,
    output coord_t count,
    output phase_e phase,
    output logic   wrap
);

    localparam int     TOTAL      = ACTIVE + FP + SYNC + BP;
    localparam coord_t LAST       = coord_t'(TOTAL - 1);
    localparam coord_t FP_START   = coord_t'(ACTIVE);
    localparam coord_t SYNC_START = coord_t'(ACTIVE + FP);
    localparam coord_t BP_START   = coord_t'(ACTIVE + FP + SYNC);

    coord_t count_nxt;
    phase_e phase_q;

    // Current position is the last of the axis; the next advance returns to 0.
    assign wrap = (count == LAST);

    // Next position: step or wrap on advance, otherwise hold.
    always_comb begin
        count_nxt = count;
        if (i_adv) begin
            count_nxt = wrap ? '0 : count + coord_t'(1);
        end
    end

    // Phase of the next position, so the parent can register decoded outputs in step with count.
    always_comb begin
        phase = phase_q;
        if (count_nxt == '0) begin
            phase = PH_ACTIVE;
        end else if (count_nxt == FP_START) begin
            phase = PH_FP;
        end else if (count_nxt == SYNC_START) begin
            phase = PH_SYNC;
        end else if (count_nxt == BP_START) begin
            phase = PH_BP;
        end
    end

    // Position and phase state; reset parks at the last position so the first advance lands on 0.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            count   <= LAST;
            phase_q <= PH_BP;
        end else begin
            count   <= count_nxt;
            phase_q <= phase;
        end
    end

endmodule

// File: rtl/vga_sync_gen.sv
// VGA 640x480@60 timing generator on the system clock, stepped by the pixel strobe i_pix_en.
// Latency: all outputs registered and aligned with o_hcount/o_vcount (zero skew between them).
// Backpressure: none; outputs hold on cycles without i_pix_en. Optional VGA_SYNC_MOVTICK_EN adds o_mov_tick.
module vga_sync_gen
    import vga_timing_pkg::*;
#(
    parameter int   H_ACTIVE = VGA_H_ACTIVE,
    parameter int   H_FP     = VGA_H_FP,
    parameter int   H_SYNC   = VGA_H_SYNC,
    parameter int   H_BP     = VGA_H_BP,
    parameter int   V_ACTIVE = VGA_V_ACTIVE,
    parameter int   V_FP     = VGA_V_FP,
    parameter int   V_SYNC   = VGA_V_SYNC,
    parameter int   V_BP     = VGA_V_BP,
    parameter logic SYNC_POL = 1'b0,
    parameter int   MOV_DIV  = 1
) (
    input  logic   i_clk,
    input  logic   i_rst,
    input  logic   i_pix_en,
    output coord_t o_hcount,
    output coord_t o_vcount,
    output logic   o_hsync,
    output logic   o_vsync,
    output logic   o_active,
    output logic   o_frame_start,
    output logic   o_mov_tick
);

    phase_e h_phase;
    phase_e v_phase;
    logic   h_wrap;
    logic   v_wrap;
    logic   v_adv;
    logic   frame_nxt;

    // Lines advance only on the strobe that wraps the pixel counter.
    assign v_adv     = i_pix_en & h_wrap;
    assign frame_nxt = v_adv & v_wrap;

    vga_axis_counter #(
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP),
        .SYNC   (H_SYNC),
        .BP     (H_BP)
    ) u_h (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_adv  (i_pix_en),
        .count  (o_hcount),
        .phase  (h_phase),
        .wrap   (h_wrap)
    );

    vga_axis_counter #(
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP),
        .SYNC   (V_SYNC),
        .BP     (V_BP)
    ) u_v (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_adv  (v_adv),
        .count  (o_vcount),
        .phase  (v_phase),
        .wrap   (v_wrap)
    );

    // Syncs and active flag decoded from next-state phases; frame_start is a single-cycle pulse.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_hsync       <= ~SYNC_POL;
            o_vsync       <= ~SYNC_POL;
            o_active      <= 1'b0;
            o_frame_start <= 1'b0;
        end else begin
            o_frame_start <= frame_nxt;
            if (i_pix_en) begin
                o_hsync  <= (h_phase == PH_SYNC) ? SYNC_POL : ~SYNC_POL;
                o_vsync  <= (v_phase == PH_SYNC) ? SYNC_POL : ~SYNC_POL;
                o_active <= (h_phase == PH_ACTIVE) && (v_phase == PH_ACTIVE);
            end
        end
    end

`ifdef VGA_SYNC_MOVTICK_EN
    localparam int                MOV_W    = (MOV_DIV > 1) ? $clog2(MOV_DIV) : 1;
    localparam logic [MOV_W-1:0] MOV_LAST = MOV_W'(MOV_DIV - 1);

    logic [MOV_W-1:0] mov_cnt;

    // Frame counter 0..MOV_DIV-1; the tick fires with the frame_start that wraps it.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            mov_cnt    <= '0;
            o_mov_tick <= 1'b0;
        end else begin
            o_mov_tick <= frame_nxt && (mov_cnt == MOV_LAST);
            if (frame_nxt) begin
                mov_cnt <= (mov_cnt == MOV_LAST) ? '0 : mov_cnt + 1'b1;
            end
        end
    end
`else
    assign o_mov_tick = 1'b0;
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: full-size instance for line timing, reduced-size instance for whole frames.
// Latency: expected outputs compared one cycle after each driven strobe.
// Backpressure: n/a.
module tb_vga_sync_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       pix_en;

    logic [9:0] d_h, d_v, s_h, s_v;
    logic       d_hs, d_vs, d_act, d_fs, d_mt;
    logic       s_hs, s_vs, s_act, s_fs, s_mt;

    vga_sync_gen dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_pix_en      (pix_en),
        .o_hcount      (d_h),
        .o_vcount      (d_v),
        .o_hsync       (d_hs),
        .o_vsync       (d_vs),
        .o_active      (d_act),
        .o_frame_start (d_fs),
        .o_mov_tick    (d_mt)
    );

    // Reduced timing: 16 pixels x 9 lines = 144 strobes per frame, active-high syncs.
    vga_sync_gen #(
        .H_ACTIVE (8), .H_FP (2), .H_SYNC (3), .H_BP (3),
        .V_ACTIVE (4), .V_FP (1), .V_SYNC (2), .V_BP (2),
        .SYNC_POL (1'b1), .MOV_DIV (3)
    ) dut_s (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_pix_en      (pix_en),
        .o_hcount      (s_h),
        .o_vcount      (s_v),
        .o_hsync       (s_hs),
        .o_vsync       (s_vs),
        .o_active      (s_act),
        .o_frame_start (s_fs),
        .o_mov_tick    (s_mt)
    );

    wire [24:0] d_obs = {d_h, d_v, d_hs, d_vs, d_act, d_fs, d_mt};
    wire [24:0] s_obs = {s_h, s_v, s_hs, s_vs, s_act, s_fs, s_mt};

    typedef struct {
        int h;
        int v;
        int fc;
        bit fs;
        bit mt;
    } mst_t;

    mst_t       md, ms;
    logic [24:0] q_d[$];
    logic [24:0] q_s[$];
    int         n_tests = 0;
    int         n_fail  = 0;
    int         fs_cnt  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic mst_t m_rst(input int ht, input int vt);
        mst_t r;
        r.h = ht - 1; r.v = vt - 1; r.fc = 0; r.fs = 1'b0; r.mt = 1'b0;
        return r;
    endfunction

    function automatic mst_t m_step(input mst_t s, input bit en, input int ht, input int vt, input int div);
        mst_t n = s;
        n.fs = 1'b0;
        n.mt = 1'b0;
        if (en) begin
            if (s.h == ht - 1) begin
                n.h = 0;
                if (s.v == vt - 1) begin
                    n.v  = 0;
                    n.fs = 1'b1;
                end else begin
                    n.v = s.v + 1;
                end
            end else begin
                n.h = s.h + 1;
            end
            if (n.fs) begin
                if (s.fc == div - 1) begin
                    n.fc = 0;
                    n.mt = 1'b1;
                end else begin
                    n.fc = s.fc + 1;
                end
            end
        end
`ifndef VGA_SYNC_MOVTICK_EN
        n.mt = 1'b0;
`endif
        return n;
    endfunction

    function automatic logic [24:0] m_obs(input mst_t s, input int ha, input int hf, input int hsn,
                                          input int va, input int vf, input int vsn, input bit pol);
        bit hs, vs, act;
        hs  = (s.h >= ha + hf && s.h < ha + hf + hsn) ? pol : ~pol;
        vs  = (s.v >= va + vf && s.v < va + vf + vsn) ? pol : ~pol;
        act = (s.h < ha) && (s.v < va);
        return {10'(s.h), 10'(s.v), hs, vs, act, s.fs, s.mt};
    endfunction

    task automatic push_exp();
        q_d.push_back(m_obs(md, 640, 16, 96, 480, 10, 2, 1'b0));
        q_s.push_back(m_obs(ms, 8, 2, 3, 4, 1, 2, 1'b1));
    endtask

    task automatic pop_cmp();
        check("d_state", {7'd0, d_obs}, {7'd0, q_d.pop_front()});
        check("s_state", {7'd0, s_obs}, {7'd0, q_s.pop_front()});
    endtask

    // One clock cycle with the given strobe value; expectation pushed on drive, popped on output.
    task automatic cyc(input bit en);
        @(negedge clk);
        pix_en = en;
        md = m_step(md, en, 800, 525, 1);
        ms = m_step(ms, en, 16, 9, 3);
        push_exp();
        @(posedge clk);
        #1;
        pop_cmp();
        if (s_fs === 1'b1) begin
            fs_cnt++;
`ifdef VGA_SYNC_MOVTICK_EN
            check("s_mov_tick", {31'd0, s_mt}, {31'd0, (fs_cnt % 3) == 0});
`else
            check("s_mov_tick", {31'd0, s_mt}, 32'd0);
`endif
        end
    endtask

    // Asynchronous reset taking effect immediately, then released with no strobe pending.
    task automatic do_reset();
        @(negedge clk);
        pix_en = 1'b0;
        rst    = 1'b1;
        #1;
        md = m_rst(800, 525);
        ms = m_rst(16, 9);
        fs_cnt = 0;
        push_exp();
        pop_cmp();
        check("rst_h", {22'd0, d_h}, 32'd799);
        check("rst_v", {22'd0, d_v}, 32'd524);
        check("rst_syncs", {30'd0, d_hs, d_vs}, 32'd3);
        check("rst_act_fs", {30'd0, d_act, d_fs}, 32'd0);
        check("rst_s_syncs", {30'd0, s_hs, s_vs}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Runs nfr reduced-size frames with a strobe pattern, checking frame length and vsync width.
    task automatic run_frames(input int mode, input int nfr, input int budget);
        int  frames = 0;
        int  strobes = 0;
        int  vs_cnt = 0;
        int  ncyc = 0;
        bit  started = 1'b0;
        bit  en;
        while (frames < nfr && ncyc < budget) begin
            en = (mode == 0) ? ((ncyc % 4) == 0) : ($urandom_range(0, 1) == 1);
            cyc(en);
            ncyc++;
            if (en) begin
                if (s_fs) begin
                    if (started) begin
                        check("s_frame_len", strobes, 144);
                        check("s_vsync_len", vs_cnt, 32);
                        frames++;
                    end
                    started = 1'b1;
                    strobes = 1;
                    vs_cnt  = s_vs ? 1 : 0;
                end else begin
                    strobes++;
                    if (s_vs) vs_cnt++;
                end
            end
        end
        check("frames_seen", frames, nfr);
    endtask

    initial begin
        int lows;
        int first;
        int last;
        rst    = 1'b1;
        pix_en = 1'b0;
        md = m_rst(800, 525);
        ms = m_rst(16, 9);
        repeat (2) @(posedge clk);
        #1;
        push_exp();
        pop_cmp();
        check("reset_h", {22'd0, d_h}, 32'd799);
        check("reset_v", {22'd0, d_v}, 32'd524);
        @(negedge clk);
        rst = 1'b0;

        // First strobe wraps to the origin.
        cyc(1'b1);
        check("t1_h", {22'd0, d_h}, 32'd0);
        check("t1_v", {22'd0, d_v}, 32'd0);
        check("t1_fs", {31'd0, d_fs}, 32'd1);
        check("t1_act", {31'd0, d_act}, 32'd1);
        cyc(1'b0);
        check("t1_fs_clr", {31'd0, d_fs}, 32'd0);

        // One full line at full strobe rate.
        lows = 0; first = -1; last = -1;
        for (int k = 1; k <= 800; k++) begin
            cyc(1'b1);
            if (d_hs == 1'b0) begin
                lows++;
                if (first < 0) first = k;
                last = k;
            end
        end
        check("t2_hs_len", lows, 96);
        check("t2_hs_first", first, 656);
        check("t2_hs_last", last, 751);
        check("t2_v", {22'd0, d_v}, 32'd1);
        check("t2_h", {22'd0, d_h}, 32'd0);

        // Whole frames with 1-in-4 strobes, then random gaps.
        run_frames(0, 4, 4000);
        run_frames(1, 4, 4000);

        // Reset mid-frame, then resume from the origin.
        do_reset();
        for (int k = 0; k < 301; k++) cyc(1'b1);
        check("t5_pre_h", {22'd0, d_h}, 32'd300);
        do_reset();
        cyc(1'b1);
        check("t5_h", {22'd0, d_h}, 32'd0);
        check("t5_v", {22'd0, d_v}, 32'd0);
        check("t5_fs", {31'd0, d_fs}, 32'd1);
        run_frames(0, 3, 3000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
